// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight branch predictions awaiting their retire-side outcome.
// Produces registered training updates and the resolved global history; optional stats via STATS_EN.
module branch_resolution_queue #(
    parameter int DEPTH    = 8,
    parameter int PTR_W    = 3,
    parameter int HIST_LEN = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pred_valid,
    input  logic [63:0]         pred_ip,
    input  logic                pred_taken,
    output logic                pred_ready,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic                flush,
    output logic                upd_valid,
    output logic [63:0]         upd_ip,
    output logic                upd_taken,
    output logic                upd_mispredict,
    output logic [HIST_LEN-1:0] ghr,
    output logic [PTR_W:0]      occupancy,
    output logic                underflow_err,
    output logic [CNT_W-1:0]    branch_cnt,
    output logic [CNT_W-1:0]    mispredict_cnt
);

    localparam logic [PTR_W:0]   FULL_OCC = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [63:0]         ip_mem_r    [DEPTH];
    logic                taken_mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W:0]      occ_r;
    logic                upd_valid_r;
    logic [63:0]         upd_ip_r;
    logic                upd_taken_r;
    logic                upd_mispredict_r;
    logic [HIST_LEN-1:0] ghr_r;
    logic                underflow_r;
    logic                push_s;
    logic                pop_s;
    logic                mispredict_s;

    assign pred_ready     = (occ_r != FULL_OCC);
    assign occupancy      = occ_r;
    assign upd_valid      = upd_valid_r;
    assign upd_ip         = upd_ip_r;
    assign upd_taken      = upd_taken_r;
    assign upd_mispredict = upd_mispredict_r;
    assign ghr            = ghr_r;
    assign underflow_err  = underflow_r;

    // Accepted push/pop this cycle; flush overrides both.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        mispredict_s = taken_mem_r[rd_ptr_r] ^ res_taken;
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = pred_valid && (occ_r != FULL_OCC);
            pop_s  = res_valid && (occ_r != {(PTR_W+1){1'b0}});
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ip_mem_r[wr_ptr_r]    <= pred_ip;
            taken_mem_r[wr_ptr_r] <= pred_taken;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Training update, history shift and sticky underflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid_r      <= 1'b0;
            upd_ip_r         <= 64'd0;
            upd_taken_r      <= 1'b0;
            upd_mispredict_r <= 1'b0;
            ghr_r            <= {HIST_LEN{1'b0}};
            underflow_r      <= 1'b0;
        end else begin
            upd_valid_r <= pop_s;
            if (pop_s) begin
                upd_ip_r         <= ip_mem_r[rd_ptr_r];
                upd_taken_r      <= res_taken;
                upd_mispredict_r <= mispredict_s;
                ghr_r            <= {ghr_r[HIST_LEN-2:0], res_taken};
            end
            if (res_valid && (occ_r == {(PTR_W+1){1'b0}})) underflow_r <= 1'b1;
        end
    end

`ifdef STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    // Saturating resolution statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            if (branch_cnt_r != CNT_MAX) branch_cnt_r <= branch_cnt_r + CNT_ONE;
            if (mispredict_s && (mispredict_cnt_r != CNT_MAX))
                mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
        end
    end

    assign branch_cnt     = branch_cnt_r;
    assign mispredict_cnt = mispredict_cnt_r;
`else
    assign branch_cnt     = {CNT_W{1'b0}};
    assign mispredict_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed self-checking bench for branch_resolution_queue; expectations are hand-computed.
module tb_branch_resolution_queue;

    logic        clk;
    logic        reset_n;
    logic        pred_valid;
    logic [63:0] pred_ip;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        upd_valid;
    logic [63:0] upd_ip;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [15:0] ghr;
    logic [3:0]  occupancy;
    logic        underflow_err;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int n_checks;
    int n_fail;

`ifdef STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    branch_resolution_queue dut (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_ip(pred_ip), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .upd_valid(upd_valid), .upd_ip(upd_ip), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ghr(ghr), .occupancy(occupancy),
        .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        pred_ip    = 64'd0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        logic tk;
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("rst_occ",   64'(occupancy), 64'd0);
        check("rst_ready", 64'(pred_ready), 64'd1);
        check("rst_upd",   64'(upd_valid), 64'd0);
        check("rst_ghr",   64'(ghr), 64'd0);
        check("rst_uflow", 64'(underflow_err), 64'd0);
        check("rst_bcnt",  64'(branch_cnt), 64'd0);
        reset_n = 1'b1;
        cyc();

        // basic mispredict
        pred_valid = 1'b1; pred_ip = 64'h1000; pred_taken = 1'b1;
        cyc();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b0;
        cyc();
        res_valid = 1'b0;
        check("t1_valid", 64'(upd_valid), 64'd1);
        check("t1_ip",    upd_ip, 64'h1000);
        check("t1_taken", 64'(upd_taken), 64'd0);
        check("t1_misp",  64'(upd_mispredict), 64'd1);
        check("t1_ghr",   64'(ghr), 64'h0000);
        check("t1_occ",   64'(occupancy), 64'd0);
        cyc();
        check("t1_pulse", 64'(upd_valid), 64'd0);

        // fill, dropped push while full, in-order drain
        for (int i = 0; i < 8; i++) begin
            pred_valid = 1'b1; pred_ip = 64'h10 + 64'(i); pred_taken = 1'(i % 2);
            cyc();
        end
        check("t2_ready", 64'(pred_ready), 64'd0);
        check("t2_occ8",  64'(occupancy), 64'd8);
        pred_ip = 64'h99; pred_taken = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
        cyc();
        pred_valid = 1'b0;
        check("t2_occ7",  64'(occupancy), 64'd7);
        check("t2_ip0",   upd_ip, 64'h10);
        for (int k = 1; k < 8; k++) begin
            cyc();
            check("t2_dvalid", 64'(upd_valid), 64'd1);
            check("t2_dip",    upd_ip, 64'h10 + 64'(k));
            check("t2_dmisp",  64'(upd_mispredict), 64'(k % 2));
        end
        res_valid = 1'b0;
        cyc();
        check("t2_empty", 64'(occupancy), 64'd0);
        check("t2_noupd", 64'(upd_valid), 64'd0);

        // wrap-around with alternating outcomes
        for (int i = 0; i < 20; i++) begin
            tk = (i % 2 == 0);
            pred_valid = 1'b1; pred_ip = 64'h200 + 64'(i); pred_taken = tk;
            cyc();
            pred_valid = 1'b0; res_valid = 1'b1; res_taken = tk;
            cyc();
            res_valid = 1'b0;
            check("t3_ip",   upd_ip, 64'h200 + 64'(i));
            check("t3_misp", 64'(upd_mispredict), 64'd0);
        end
        check("t3_ghr", 64'(ghr), 64'hAAAA);

        // underflow
        res_valid = 1'b1; res_taken = 1'b1;
        cyc();
        res_valid = 1'b0;
        check("t4_uflow",  64'(underflow_err), 64'd1);
        check("t4_noupd",  64'(upd_valid), 64'd0);
        check("t4_ghr",    64'(ghr), 64'hAAAA);
        cyc();
        check("t4_sticky", 64'(underflow_err), 64'd1);
        pred_valid = 1'b1; pred_ip = 64'h300; pred_taken = 1'b0;
        cyc();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
        cyc();
        res_valid = 1'b0;
        check("t4_ip",   upd_ip, 64'h300);
        check("t4_misp", 64'(upd_mispredict), 64'd1);
        check("t4_ghr2", 64'(ghr), 64'h5555);
        // push into empty queue with same-cycle resolve
        pred_valid = 1'b1; pred_ip = 64'h400; pred_taken = 1'b0;
        res_valid = 1'b1; res_taken = 1'b0;
        cyc();
        pred_valid = 1'b0;
        check("t4_eocc", 64'(occupancy), 64'd1);
        check("t4_eupd", 64'(upd_valid), 64'd0);
        cyc();
        res_valid = 1'b0;
        check("t4_eip",  upd_ip, 64'h400);
        check("t4_eghr", 64'(ghr), 64'hAAAA);

        // flush
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1; pred_ip = 64'h500 + 64'(i); pred_taken = 1'b1;
            cyc();
        end
        check("t5_occ4", 64'(occupancy), 64'd4);
        flush = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        cyc();
        idle_inputs();
        check("t5_occ0", 64'(occupancy), 64'd0);
        check("t5_noupd", 64'(upd_valid), 64'd0);
        check("t5_ghr",  64'(ghr), 64'hAAAA);
        cyc();
        check("t5_noupd2", 64'(upd_valid), 64'd0);
        // 31 resolutions so far, 6 mispredicts
        check("stat_bcnt", 64'(branch_cnt),     STATS_ON ? 64'd31 : 64'd0);
        check("stat_mcnt", 64'(mispredict_cnt), STATS_ON ? 64'd6  : 64'd0);

        // asynchronous reset mid-stream
        pred_valid = 1'b1; pred_ip = 64'h600; pred_taken = 1'b0;
        cyc();
        pred_ip = 64'h601;
        cyc();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
        cyc();
        res_valid = 1'b0;
        check("t6_pre", 64'(upd_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_valid", 64'(upd_valid), 64'd0);
        check("t6_ip",    upd_ip, 64'd0);
        check("t6_taken", 64'(upd_taken), 64'd0);
        check("t6_misp",  64'(upd_mispredict), 64'd0);
        check("t6_ghr",   64'(ghr), 64'd0);
        check("t6_occ",   64'(occupancy), 64'd0);
        check("t6_uflow", 64'(underflow_err), 64'd0);
        check("t6_bcnt",  64'(branch_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("t6_post_upd", 64'(upd_valid), 64'd0);
        check("t6_post_occ", 64'(occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
